// File: rtl/axi_burst_master_pkg.sv
// axi_burst_master_pkg: AXI response/burst codes and the master FSM state type.
package axi_burst_master_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ, ST_DONE} state_t;
endpackage

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 full bus bundle between the self-test master and a slave.
interface axi_burst_master_if #(
    parameter int ID_W   = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_master_rd_checker.sv
// axi_burst_master_rd_checker: counts read beats and flags any beat whose data, ID, response or
// RLAST position disagrees with the pattern that was written.
module axi_burst_master_rd_checker
    import axi_burst_master_pkg::*;
#(
    parameter int ID_W   = 2,
    parameter int DATA_W = 32,
    parameter int LEN    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_beat,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic [ID_W-1:0]   i_rid,
    input  logic              i_rlast,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [ID_W-1:0]   i_id,
    output logic              o_last,
    output logic              o_err
);
    localparam int CW = $clog2(LEN) + 1;
    logic [CW-1:0] r_beat;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) r_beat <= '0;
        else if (i_beat) r_beat <= r_beat + 1'b1;
    end
    assign o_last = r_beat == CW'(LEN - 1);
    assign o_err  = i_beat && (i_rdata != i_seed + DATA_W'(r_beat) || i_rresp != RESP_OKAY ||
                               i_rid != i_id || i_rlast != o_last);
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: on each INIT writes one INCR burst of seed+beat, waits for B, reads it back
// and checks every beat; reports a done pulse and a sticky error flag.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int          C_M_AXI_ID_WIDTH     = 2,
    parameter int          C_M_AXI_DATA_WIDTH   = 32,
    parameter int          C_M_AXI_ADDR_WIDTH   = 5,
    parameter int          C_M_AXI_BURST_LEN    = 8,
    parameter int unsigned C_M_TARGET_BASE_ADDR = 0
) (
    input  logic M_AXI_ACLK,
    input  logic M_AXI_ARESETN,
    input  logic INIT_AXI_TXN,
    output logic TXN_DONE,
    output logic ERROR,
    output logic BUSY,
    axi_burst_master_if.master m_axi
);
    localparam int IW  = C_M_AXI_ID_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;
    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int LEN = C_M_AXI_BURST_LEN;
    localparam int CW  = $clog2(LEN) + 1;
    state_t        r_state, w_next;
    logic          r_awvalid, r_wvalid, r_arvalid, r_aw_done, r_w_done, r_err;
    logic [CW-1:0] r_wbeat;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_seed;
    logic          w_aw_hs, w_w_hs, w_wlast, w_b_hs, w_b_err, w_r_hs, w_rd_last, w_rd_err;
    assign w_aw_hs = r_awvalid && m_axi.awready;
    assign w_w_hs  = r_wvalid && m_axi.wready;
    assign w_wlast = r_wbeat == CW'(LEN - 1);
    assign w_b_hs  = r_state == ST_WRESP && m_axi.bvalid;
    assign w_b_err = w_b_hs && (m_axi.bresp != RESP_OKAY || m_axi.bid != r_id);
    assign w_r_hs  = r_state == ST_READ && m_axi.rvalid;
    axi_burst_master_rd_checker #(.ID_W(IW), .DATA_W(DW), .LEN(LEN)) u_chk (
        .i_clk(M_AXI_ACLK), .i_rst_n(M_AXI_ARESETN), .i_clear(r_state == ST_IDLE), .i_beat(w_r_hs),
        .i_rdata(m_axi.rdata), .i_rresp(m_axi.rresp), .i_rid(m_axi.rid), .i_rlast(m_axi.rlast),
        .i_seed(r_seed), .i_id(r_id), .o_last(w_rd_last), .o_err(w_rd_err)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = INIT_AXI_TXN ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_next = ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && w_wlast))) ? ST_WRESP : ST_WRITE;
            ST_WRESP: w_next = m_axi.bvalid ? ST_READ : ST_WRESP;
            ST_READ:  w_next = (w_r_hs && w_rd_last) ? ST_DONE : ST_READ;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_wbeat   <= '0;
            r_id      <= '0;
            r_seed    <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err || w_b_err || w_rd_err;
            if (r_state == ST_IDLE && INIT_AXI_TXN) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_wbeat   <= '0;
            end
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs && w_wlast) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end else if (w_w_hs) r_wbeat <= r_wbeat + 1'b1;
            if (w_b_hs) r_arvalid <= 1'b1;
            if (r_arvalid && m_axi.arready) r_arvalid <= 1'b0;
            if (r_state == ST_DONE) begin
                r_id   <= r_id + 1'b1;
                r_seed <= r_seed + DW'(LEN);
            end
        end
    end
    assign TXN_DONE      = r_state == ST_DONE;
    assign BUSY          = r_state != ST_IDLE;
    assign ERROR         = r_err;
    assign m_axi.awid    = r_id;
    assign m_axi.awaddr  = AW'(C_M_TARGET_BASE_ADDR);
    assign m_axi.awlen   = 8'(LEN - 1);
    assign m_axi.awsize  = 3'($clog2(DW / 8));
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_seed + DW'(r_wbeat);
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = r_wvalid && w_wlast;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_state == ST_WRESP;
    assign m_axi.arid    = r_id;
    assign m_axi.araddr  = AW'(C_M_TARGET_BASE_ADDR);
    assign m_axi.arlen   = 8'(LEN - 1);
    assign m_axi.arsize  = 3'($clog2(DW / 8));
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_state == ST_READ;
endmodule
